ahb_slave_multi_ep: RTL and testbench

AHB-Lite slave register interface for the USB endpoint controller, generalised to `NUM_EP` endpoints. Each endpoint has its own 16-byte register window. Data-buffer reads insert wait states sized to the buffer read latency. Errors use the full two-cycle AHB response, and a maskable interrupt line is added. The block sits between the SoC AHB bus and the per-endpoint RX/TX packet engines and data buffers.

---
 rtl/usb_pkg.sv | 8 +
 rtl/ahb_slave_multi_ep_if.sv | 10 +
 rtl/ahb_ep_regs.sv | 62 ++++++
 rtl/ahb_slave_multi_ep.sv | 136 +++++++++++++
 tb/tb_ahb_slave_multi_ep.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared packet codes, AHB encodings, register offsets and slave FSM states
package usb_pkg;
  localparam logic [3:0] PKT_IDLE = 4'd0, PKT_IN = 4'd1, PKT_OUT = 4'd2, PKT_ACK = 4'd3, PKT_NACK = 4'd4;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic [3:0] OFF_DATA = 4'h0, OFF_STATUS = 4'h4, OFF_ERROR = 4'h6, OFF_OCC = 4'h8;
  localparam logic [3:0] OFF_TXCTL = 4'hC, OFF_FLUSH = 4'hD, OFF_IEN = 4'hE;
  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ERR1, ST_ERR2} ahb_state_t;
endpackage

// File: rtl/ahb_slave_multi_ep_if.sv
// ahb_slave_multi_ep_if: AHB-Lite bus bundle between the SoC master and the endpoint slave
interface ahb_slave_multi_ep_if #(parameter int ADDR_W = 5);
  logic hsel, hwrite, hresp, hready;
  logic [ADDR_W-1:0] haddr;
  logic [1:0] htrans, hsize;
  logic [2:0] hburst;
  logic [31:0] hwdata, hrdata;
  modport master (output hsel, hwrite, haddr, htrans, hsize, hburst, hwdata, input hrdata, hresp, hready);
  modport slave (input hsel, hwrite, haddr, htrans, hsize, hburst, hwdata, output hrdata, hresp, hready);
endinterface

// File: rtl/ahb_ep_regs.sv
// ahb_ep_regs: one endpoint's status, error, TX control, flush and IRQ-enable registers
module ahb_ep_regs
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rx_packet,
  input  logic        rx_data_ready,
  input  logic        rx_transfer_active,
  input  logic        rx_error,
  input  logic        tx_transfer_active,
  input  logic        tx_error,
  input  logic        occ_zero,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  off,
  input  logic [7:0]  wdata,
  output logic [15:0] status,
  output logic [15:0] err,
  output logic [2:0]  tx_ctl,
  output logic        clear,
  output logic [5:0]  ien,
  output logic        tx_bad,
  output logic        irq_t
);
  logic rx_d, tx_d, e_rx, e_tx, rx_rise, rx_fall, tx_fall, rd_st, rd_err;
  logic [4:0] st, st_set;
  always_comb begin
    rx_rise = rx_transfer_active & ~rx_d;
    rx_fall = ~rx_transfer_active & rx_d;
    tx_fall = ~tx_transfer_active & tx_d;
    rd_st = re && off[3:1] == OFF_STATUS[3:1];
    rd_err = re && off[3:1] == OFF_ERROR[3:1];
    st_set = {rx_fall && rx_packet == PKT_NACK, rx_fall && rx_packet == PKT_ACK,
              rx_fall && rx_packet == PKT_OUT, rx_fall && rx_packet == PKT_IN, rx_data_ready};
    tx_bad = wdata == 8'd0 || wdata > 8'd4 || tx_ctl != 3'd0;
    status = {6'b0, tx_transfer_active, rx_transfer_active, 3'b0, st};
    err = {7'b0, e_tx, 7'b0, e_rx};
    irq_t = |(st & ien[4:0]) || (ien[5] && (e_rx || e_tx));
  end
  // new events take priority over clear-on-read in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_d <= 1'b0;
      tx_d <= 1'b0;
      st <= '0;
      e_rx <= 1'b0;
      e_tx <= 1'b0;
      tx_ctl <= '0;
      clear <= 1'b0;
      ien <= '0;
    end else begin
      rx_d <= rx_transfer_active;
      tx_d <= tx_transfer_active;
      st <= st_set | (st & ~{{4{rd_st}}, rd_st || rx_rise});
      e_rx <= rx_error || (e_rx && !rd_err);
      e_tx <= tx_error || (e_tx && !rd_err);
      tx_ctl <= we && off == OFF_TXCTL ? wdata[2:0] : tx_fall ? 3'd0 : tx_ctl;
      clear <= we && off == OFF_FLUSH && wdata != 8'd0 ? 1'b1 : occ_zero ? 1'b0 : clear;
      ien <= we && off == OFF_IEN ? wdata[5:0] : ien;
    end
endmodule

// File: rtl/ahb_slave_multi_ep.sv
// ahb_slave_multi_ep: AHB-Lite register slave for NUM_EP USB endpoints with
// wait-stated buffer reads, two-cycle error responses and a maskable interrupt
module ahb_slave_multi_ep
  import usb_pkg::*;
#(
  parameter int NUM_EP = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int RD_LATENCY = 1,
  localparam int EP_W = NUM_EP > 1 ? $clog2(NUM_EP) : 1,
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  ahb_slave_multi_ep_if.slave     bus,
  input  logic [4*NUM_EP-1:0]     rx_packet,
  input  logic [NUM_EP-1:0]       rx_data_ready,
  input  logic [NUM_EP-1:0]       rx_transfer_active,
  input  logic [NUM_EP-1:0]       rx_error,
  input  logic [NUM_EP-1:0]       tx_transfer_active,
  input  logic [NUM_EP-1:0]       tx_error,
  output logic [3*NUM_EP-1:0]     tx_packet,
  output logic [NUM_EP-1:0]       tx_start,
  output logic [NUM_EP-1:0]       d_mode,
  input  logic [OCC_W*NUM_EP-1:0] buffer_occupancy,
  input  logic [31:0]             rx_data,
  output logic [EP_W-1:0]         buf_sel,
  output logic [1:0]              get_rx_data,
  output logic [1:0]              store_tx_data,
  output logic [31:0]             tx_data,
  output logic [NUM_EP-1:0]       clear,
  output logic                    irq
);
  localparam int NE = 2 ** EP_W;
  ahb_state_t state;
  logic [1:0] cnt, dp_sz;
  logic dp_v, dp_wr, acc, a_err, a_rd, tx_bad_dp, last, rdy, unused;
  logic [EP_W-1:0] dp_ep, a_ep;
  logic [3:0] dp_off, a_off;
  logic [31:0] reg_rd, mask;
  logic [OCC_W-1:0] occ [NE];
  logic [15:0] status [NE];
  logic [15:0] err [NE];
  logic [2:0] tx_ctl [NE];
  logic [5:0] ien [NE];
  logic [NE-1:0] clr_v, tx_bad, irq_t;
  genvar e;
  for (e = 0; e < NE; e++) begin : g_ep
    if (e < NUM_EP) begin : g_on
      assign occ[e] = buffer_occupancy[OCC_W*e +: OCC_W];
      assign tx_start[e] = |tx_ctl[e];
      assign tx_packet[3*e +: 3] = tx_ctl[e] - {2'b0, |tx_ctl[e]};
      assign clear[e] = clr_v[e];
      ahb_ep_regs u_regs (
        .clk, .rst,
        .rx_packet(rx_packet[4*e +: 4]), .rx_data_ready(rx_data_ready[e]),
        .rx_transfer_active(rx_transfer_active[e]), .rx_error(rx_error[e]),
        .tx_transfer_active(tx_transfer_active[e]), .tx_error(tx_error[e]),
        .occ_zero(occ[e] == '0),
        .we(dp_v && dp_wr && dp_ep == EP_W'(e) && !tx_bad_dp),
        .re(dp_v && !dp_wr && dp_ep == EP_W'(e)),
        .off(dp_off), .wdata(bus.hwdata[7:0]),
        .status(status[e]), .err(err[e]), .tx_ctl(tx_ctl[e]), .clear(clr_v[e]),
        .ien(ien[e]), .tx_bad(tx_bad[e]), .irq_t(irq_t[e])
      );
    end else begin : g_off
      assign occ[e] = '0;
      assign status[e] = '0;
      assign err[e] = '0;
      assign tx_ctl[e] = '0;
      assign ien[e] = '0;
      assign clr_v[e] = 1'b0;
      assign tx_bad[e] = 1'b0;
      assign irq_t[e] = 1'b0;
    end
  end
  // address-phase decode: every illegal access is known here except a bad TX control value
  always_comb begin
    a_ep = bus.haddr[EP_W+3:4];
    a_off = bus.haddr[3:0];
    acc = rdy && bus.hsel && bus.htrans[1];
    a_rd = a_off[3:2] == OFF_DATA[3:2] && !bus.hwrite;
    a_err = bus.hsize == 2'd3
         || (bus.hsize == 2'd1 && bus.haddr[0]) || (bus.hsize == 2'd2 && bus.haddr[1:0] != 2'd0)
         || a_off inside {4'h9, 4'hA, 4'hB, 4'hF}
         || (bus.hwrite && a_off inside {[4'h4:4'hB]})
         || int'(a_ep) >= NUM_EP
         || (a_off[3:2] == OFF_DATA[3:2] && (bus.hwrite ? int'(occ[a_ep]) + int'(bus.hsize) + 1 > FIFO_DEPTH
                                                        : int'(occ[a_ep]) < int'(bus.hsize) + 1));
    last = state == ST_RD_WAIT && cnt == 2'(RD_LATENCY);
    tx_bad_dp = dp_v && dp_wr && dp_off == OFF_TXCTL && tx_bad[dp_ep];
    rdy = state == ST_ERR1 ? 1'b0 : state == ST_RD_WAIT ? last : !tx_bad_dp;
    mask = dp_sz == 2'd0 ? 32'h0000_00FF : dp_sz == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    reg_rd = dp_off[3:1] == OFF_STATUS[3:1] ? {16'b0, status[dp_ep]}
           : dp_off[3:1] == OFF_ERROR[3:1] ? {16'b0, err[dp_ep]}
           : dp_off[3:2] == OFF_OCC[3:2] ? 32'(occ[dp_ep])
           : dp_off == OFF_TXCTL ? {29'b0, tx_ctl[dp_ep]}
           : dp_off == OFF_FLUSH ? {31'b0, clr_v[dp_ep]}
           : dp_off == OFF_IEN ? {26'b0, ien[dp_ep]} : 32'd0;
  end
  assign bus.hready = rdy;
  assign bus.hresp = state == ST_ERR1 || state == ST_ERR2 || tx_bad_dp;
  assign bus.hrdata = last ? rx_data & mask : dp_v && !dp_wr ? reg_rd : 32'd0;
  assign tx_data = bus.hwdata;
  assign d_mode = tx_transfer_active;
  assign unused = ^{bus.hburst, bus.htrans[0]};
  // a bad TX control write shows its first error cycle combinationally, then joins ERR2
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      dp_v <= 1'b0;
      dp_wr <= 1'b0;
      dp_ep <= '0;
      dp_off <= '0;
      dp_sz <= '0;
      buf_sel <= '0;
      get_rx_data <= '0;
      store_tx_data <= '0;
      irq <= 1'b0;
    end else begin
      irq <= |irq_t;
      cnt <= acc ? 2'd0 : cnt + 2'd1;
      dp_v <= acc && !a_err && !a_rd;
      get_rx_data <= acc && !a_err && a_rd ? bus.hsize + 2'd1 : 2'd0;
      store_tx_data <= acc && !a_err && bus.hwrite && a_off[3:2] == OFF_DATA[3:2] ? bus.hsize + 2'd1 : 2'd0;
      if (acc) begin
        state <= a_err ? ST_ERR1 : a_rd ? ST_RD_WAIT : ST_IDLE;
        dp_wr <= bus.hwrite;
        dp_ep <= a_ep;
        dp_off <= a_off;
        dp_sz <= bus.hsize;
        buf_sel <= a_err ? buf_sel : a_ep;
      end else
        state <= state == ST_ERR1 || tx_bad_dp ? ST_ERR2 : state == ST_RD_WAIT && !last ? ST_RD_WAIT : ST_IDLE;
    end
endmodule

// File: tb/tb_ahb_slave_multi_ep.sv
// tb_ahb_slave_multi_ep: directed AHB transfers against hand-computed register,
// wait-state, error-response and interrupt behaviour of a two-endpoint slave
module tb_ahb_slave_multi_ep;
  import usb_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ahb_slave_multi_ep_if #(.ADDR_W(5)) bus ();
  logic [7:0] rx_packet = '0;
  logic [1:0] rx_data_ready = '0, rx_transfer_active = '0, rx_error = '0;
  logic [1:0] tx_transfer_active = '0, tx_error = '0;
  logic [5:0] tx_packet;
  logic [1:0] tx_start, d_mode, clear, get_rx_data, store_tx_data;
  logic [13:0] buffer_occupancy = '0;
  logic [31:0] rx_data = '0, tx_data;
  logic buf_sel, irq;
  int checks = 0, errors = 0;

  ahb_slave_multi_ep #(.NUM_EP(2), .FIFO_DEPTH(64), .RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
    .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
    .tx_packet(tx_packet), .tx_start(tx_start), .d_mode(d_mode),
    .buffer_occupancy(buffer_occupancy), .rx_data(rx_data), .buf_sel(buf_sel),
    .get_rx_data(get_rx_data), .store_tx_data(store_tx_data), .tx_data(tx_data),
    .clear(clear), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input logic w, input logic [4:0] a, input logic [1:0] sz);
    bus.hsel = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = w;
    bus.haddr = a;
    bus.hsize = sz;
    step();
    bus.hsel = 1'b0;
    bus.htrans = HTRANS_IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.haddr = '0; bus.htrans = HTRANS_IDLE;
    bus.hsize = 2'd0; bus.hburst = 3'd0; bus.hwdata = '0;
    step(); step();
    @(negedge clk);
    chk("rst_hready", bus.hready, 1);
    chk("rst_hresp", bus.hresp, 0);
    chk("rst_hrdata", bus.hrdata, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_irq", irq, 0);
    chk("rst_clear", clear, 0);
    chk("rst_get_store", {get_rx_data, store_tx_data}, 0);
    step();
    rst = 1'b0;
    // occupancy read EP1
    buffer_occupancy = {7'd12, 7'd0};
    addr(0, 5'h18, 0);
    @(negedge clk);
    chk("occ_hrdata", bus.hrdata, 32'h0C);
    chk("occ_hready", bus.hready, 1);
    chk("occ_hresp", bus.hresp, 0);
    chk("occ_buf_sel", buf_sel, 1);
    step();
    // wait-stated data read EP0
    buffer_occupancy = {7'd12, 7'd8};
    addr(0, 5'h00, 2);
    @(negedge clk);
    chk("rd_get", get_rx_data, 3);
    chk("rd_wait0", bus.hready, 0);
    step();
    @(negedge clk);
    chk("rd_get_off", get_rx_data, 0);
    chk("rd_wait1", bus.hready, 0);
    step();
    rx_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_done", bus.hready, 1);
    chk("rd_hrdata", bus.hrdata, 32'hDEADBEEF);
    chk("rd_hresp", bus.hresp, 0);
    step();
    rx_data = '0;
    @(negedge clk);
    chk("rd_idle_hrdata", bus.hrdata, 0);
    // overflowing word write EP0
    buffer_occupancy = {7'd12, 7'd62};
    addr(1, 5'h00, 2);
    bus.hwdata = 32'h11223344;
    @(negedge clk);
    chk("ovf_err1", {bus.hresp, bus.hready}, 2'b10);
    chk("ovf_store", store_tx_data, 0);
    step();
    @(negedge clk);
    chk("ovf_err2", {bus.hresp, bus.hready}, 2'b11);
    chk("ovf_store2", store_tx_data, 0);
    step();
    @(negedge clk);
    chk("ovf_done", {bus.hresp, bus.hready}, 2'b01);
    // exactly-full word write is legal
    buffer_occupancy = {7'd12, 7'd61};
    addr(1, 5'h00, 2);
    bus.hwdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("wr_store", store_tx_data, 3);
    chk("wr_tx_data", tx_data, 32'hCAFEF00D);
    chk("wr_resp", {bus.hresp, bus.hready}, 2'b01);
    step();
    @(negedge clk);
    chk("wr_store_off", store_tx_data, 0);
    // TX control EP1
    addr(1, 5'h1C, 0);
    bus.hwdata = 32'h3;
    @(negedge clk);
    chk("txc_resp", {bus.hresp, bus.hready}, 2'b01);
    step();
    @(negedge clk);
    chk("txc_start", tx_start, 2'b10);
    chk("txc_packet", tx_packet, 6'h10);
    addr(0, 5'h1C, 0);
    @(negedge clk);
    chk("txc_read", bus.hrdata, 3);
    step();
    addr(1, 5'h1C, 0);
    bus.hwdata = 32'h1;
    @(negedge clk);
    chk("txc_busy_err1", {bus.hresp, bus.hready}, 2'b10);
    step();
    @(negedge clk);
    chk("txc_busy_err2", {bus.hresp, bus.hready}, 2'b11);
    step();
    chk("txc_kept", tx_packet, 6'h10);
    tx_transfer_active = 2'b10;
    @(negedge clk);
    chk("d_mode", d_mode, 2'b10);
    step();
    tx_transfer_active = 2'b00;
    step();
    @(negedge clk);
    chk("txc_cleared", {tx_start, tx_packet}, 0);
    // ACK status with IRQ enable EP0
    addr(1, 5'h0E, 0);
    bus.hwdata = 32'h08;
    step();
    rx_packet = {4'd0, PKT_ACK};
    rx_transfer_active = 2'b01;
    step();
    rx_transfer_active = 2'b00;
    step();
    @(negedge clk);
    chk("irq_registered_lag", irq, 0);
    addr(0, 5'h04, 1);
    @(negedge clk);
    chk("status_ack", bus.hrdata, 32'h0008);
    chk("irq_set", irq, 1);
    step();
    step();
    @(negedge clk);
    chk("irq_dropped", irq, 0);
    addr(0, 5'h04, 1);
    @(negedge clk);
    chk("status_cleared", bus.hrdata, 0);
    step();
    // misaligned halfword and write to occupancy
    addr(0, 5'h05, 1);
    @(negedge clk);
    chk("mis_err1", {bus.hresp, bus.hready}, 2'b10);
    step();
    @(negedge clk);
    chk("mis_err2", {bus.hresp, bus.hready}, 2'b11);
    step();
    addr(1, 5'h08, 0);
    bus.hwdata = 32'hFF;
    @(negedge clk);
    chk("ro_err1", {bus.hresp, bus.hready}, 2'b10);
    step();
    @(negedge clk);
    chk("ro_err2", {bus.hresp, bus.hready}, 2'b11);
    step();
    addr(0, 5'h0E, 0);
    @(negedge clk);
    chk("ien_unchanged", bus.hrdata, 32'h08);
    step();
    addr(0, 5'h0C, 3);
    @(negedge clk);
    chk("size3_err", {bus.hresp, bus.hready}, 2'b10);
    step();
    step();
    // back-to-back write then read of EP1 IRQ enable
    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = 1'b1; bus.haddr = 5'h1E; bus.hsize = 2'd0;
    step();
    bus.hwdata = 32'h01;
    bus.hwrite = 1'b0;
    step();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    @(negedge clk);
    chk("b2b_read", bus.hrdata, 32'h01);
    step();
    // flush EP1
    buffer_occupancy = {7'd5, 7'd0};
    addr(1, 5'h1D, 0);
    bus.hwdata = 32'h1;
    step();
    @(negedge clk);
    chk("flush_set", clear, 2'b10);
    addr(0, 5'h1D, 0);
    @(negedge clk);
    chk("flush_read", bus.hrdata, 1);
    step();
    buffer_occupancy = '0;
    step();
    @(negedge clk);
    chk("flush_done", clear, 0);
    // sticky errors
    rx_error = 2'b10;
    step();
    rx_error = 2'b00;
    addr(0, 5'h16, 1);
    @(negedge clk);
    chk("err_rx", bus.hrdata, 32'h0001);
    step();
    addr(0, 5'h16, 1);
    @(negedge clk);
    chk("err_rx_cleared", bus.hrdata, 0);
    step();
    tx_error = 2'b01;
    step();
    tx_error = 2'b00;
    addr(0, 5'h06, 1);
    @(negedge clk);
    chk("err_tx", bus.hrdata, 32'h0100);
    step();
    // reset during a wait-stated read
    buffer_occupancy = {7'd0, 7'd8};
    addr(0, 5'h00, 2);
    @(negedge clk);
    chk("abort_pre", {bus.hready, get_rx_data}, 3'b0_11);
    rst = 1'b1;
    #1;
    chk("abort_hready", bus.hready, 1);
    chk("abort_get", get_rx_data, 0);
    chk("abort_hresp", bus.hresp, 0);
    step();
    rst = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
